// File: rtl/spi_gpg_master_if.sv
// Byte-level link between the GoPiGo3 command sequencer and the SPI mode-0 shifter.
// Chip select is not carried here; the sequencer keeps ownership of it.
interface spi_gpg_master_if #(
  parameter int DATA_W = 8
);
  logic              ena_2clk;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              miso;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic              sclk;
  logic              mosi;

  modport master (
    input  ena_2clk, start, data_in, miso,
    output busy, done, data_out, sclk, mosi
  );

  modport slave (
    output ena_2clk, start, data_in, miso,
    input  busy, done, data_out, sclk, mosi
  );
endinterface

// File: rtl/spi_gpg_master.sv
// SPI mode-0 byte shifter paced by a 2x-SCLK enable pulse; MSB first, MISO sampled on SCLK rise.
// Each enable pulse advances one SCLK half-period, so at most one SCLK edge per pulse.
module spi_gpg_master #(
  parameter int DATA_W    = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  spi_gpg_master_if.master  bus
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PH_LO, PH_HI, GAP} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] data_out_q;
  logic              busy_q;
  logic              done_q;
  logic              sclk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            tx_sh_q   <= bus.data_in;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= PH_LO;
          end
        end
        PH_LO: begin
          if (bus.ena_2clk) begin
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[DATA_W-2:0], bus.miso};
            state_q <= PH_HI;
          end
        end
        PH_HI: begin
          if (bus.ena_2clk) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q < LAST_BIT) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_sh_q   <= {tx_sh_q[DATA_W-2:0], 1'b0};
              state_q   <= PH_LO;
            end else begin
              // Clearing the shifter also parks MOSI low until the next accept.
              data_out_q <= rx_sh_q;
              done_q     <= 1'b1;
              tx_sh_q    <= '0;
              bit_cnt_q  <= '0;
              if (GAP_TICKS > 0) begin
                state_q <= GAP;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          if (bus.ena_2clk) begin
            if (gap_cnt_q == LAST_GAP) begin
              busy_q    <= 1'b0;
              gap_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = tx_sh_q[DATA_W-1];
endmodule

// File: tb/tb_spi_gpg_master.sv
// Bench for spi_gpg_master: two instances (GAP_TICKS 1 and 0) share stimulus and are checked
// every cycle against a tick-count model of the transfer, plus literal checks per scenario.
module tb_spi_gpg_master;
  localparam int W  = 8;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, ena, miso, miso_q;
  logic [W-1:0] data_in;
  int           miso_mode;   // 0 loopback, 1 slave byte, 2 random, 3 constant one
  int           ena_mode;    // 0 periodic, 1 tied high, 2 random, 3 off
  int           per;
  logic [W-1:0] slave_byte;

  spi_gpg_master_if #(.DATA_W(W)) bus_a ();
  spi_gpg_master_if #(.DATA_W(W)) bus_b ();

  assign bus_a.ena_2clk = ena;
  assign bus_a.start    = start;
  assign bus_a.data_in  = data_in;
  assign bus_a.miso     = miso;
  assign bus_b.ena_2clk = ena;
  assign bus_b.start    = start;
  assign bus_b.data_in  = data_in;
  assign bus_b.miso     = miso;
  assign miso = (miso_mode == 0) ? bus_a.mosi : miso_q;

  spi_gpg_master #(.DATA_W(W), .GAP_TICKS(1)) u_dut_gap1 (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  spi_gpg_master #(.DATA_W(W), .GAP_TICKS(0)) u_dut_gap0 (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  logic         d_busy[NI], d_done[NI], d_sclk[NI], d_mosi[NI];
  logic [W-1:0] d_dout[NI];
  assign d_busy[0] = bus_a.busy;     assign d_busy[1] = bus_b.busy;
  assign d_done[0] = bus_a.done;     assign d_done[1] = bus_b.done;
  assign d_sclk[0] = bus_a.sclk;     assign d_sclk[1] = bus_b.sclk;
  assign d_mosi[0] = bus_a.mosi;     assign d_mosi[1] = bus_b.mosi;
  assign d_dout[0] = bus_a.data_out; assign d_dout[1] = bus_b.data_out;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 60) $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, idx, $time, act, exp);
    end
  endtask

  // Model: a transfer is a count of enable ticks since accept; odd ticks raise SCLK and
  // sample MISO, tick 2W ends the byte, and busy lasts until tick 2W+gap.
  int           gap_cfg[NI] = '{1, 0};
  bit           m_active[NI], m_busy[NI], m_done[NI], m_sclk[NI], m_mosi[NI];
  int           m_ticks[NI];
  logic [W-1:0] m_tx[NI], m_rx[NI], m_dout[NI];

  initial begin
    logic s_rst, s_start, s_ena, s_miso;
    logic [W-1:0] s_din;
    int k;
    for (int i = 0; i < NI; i++) begin
      m_active[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_sclk[i] = 0; m_mosi[i] = 0;
      m_ticks[i] = 0; m_tx[i] = '0; m_rx[i] = '0; m_dout[i] = '0;
    end
    forever begin
      @(negedge clk);
      #1;
      k = m_ticks[0] / 2;
      if (k > W - 1) k = W - 1;
      if (miso_mode == 1) miso_q = slave_byte[W-1-k];
      else if (miso_mode == 2) miso_q = 1'($urandom_range(1));
      else miso_q = 1'b1;
      #2;
      s_rst = rst; s_start = start; s_ena = ena; s_miso = miso; s_din = data_in;
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (s_rst) begin
          m_active[i] = 0; m_ticks[i] = 0; m_done[i] = 0; m_dout[i] = '0;
        end else begin
          m_done[i] = 0;
          if (!m_active[i]) begin
            if (s_start) begin
              m_active[i] = 1; m_ticks[i] = 0; m_tx[i] = s_din; m_rx[i] = '0;
            end
          end else if (s_ena) begin
            m_ticks[i]++;
            if (m_ticks[i] % 2 == 1) m_rx[i] = {m_rx[i][W-2:0], s_miso};
            if (m_ticks[i] == 2 * W) begin
              m_dout[i] = m_rx[i];
              m_done[i] = 1;
            end
            if (m_ticks[i] == 2 * W + gap_cfg[i]) m_active[i] = 0;
          end
        end
        m_busy[i] = m_active[i];
        m_sclk[i] = m_active[i] && (m_ticks[i] < 2 * W) && (m_ticks[i] % 2 == 1);
        m_mosi[i] = (m_active[i] && m_ticks[i] < 2 * W) ? m_tx[i][W-1-m_ticks[i]/2] : 1'b0;
      end
    end
  end

  // Enable generator: periodic mode restarts its divider when a transfer is accepted.
  initial begin
    int div;
    logic p_busy;
    div = 0; p_busy = 0; ena = 0;
    forever begin
      @(posedge clk);
      #2;
      if (d_busy[0] && !p_busy) div = 1; else div++;
      p_busy = d_busy[0];
      case (ena_mode)
        0:       ena = (div % per == 0);
        1:       ena = 1'b1;
        2:       ena = ($urandom_range(2) == 0);
        default: ena = 1'b0;
      endcase
    end
  end

  // Per-cycle compare and measurement.
  bit        chk_en = 0;
  int        cyc = 0;
  logic      p_sclk[NI], p_mosi[NI], p_bz[NI];
  int        rises[NI], dones[NI], accepts[NI], busy_hi[NI];
  int        last_fall[NI], busy_fall[NI], low_run[NI], last_low_run[NI];
  logic [15:0] mosi_rec[NI];

  task automatic clear_meas();
    for (int i = 0; i < NI; i++) begin
      rises[i] = 0; dones[i] = 0; accepts[i] = 0; busy_hi[i] = 0;
      last_fall[i] = 0; busy_fall[i] = 0; last_low_run[i] = 0; mosi_rec[i] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      p_sclk[i] = 0; p_mosi[i] = 0; p_bz[i] = 0; low_run[i] = 0;
    end
    clear_meas();
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (chk_en) begin
          check("busy", i, d_busy[i], m_busy[i]);
          check("done", i, d_done[i], m_done[i]);
          check("sclk", i, d_sclk[i], m_sclk[i]);
          check("mosi", i, d_mosi[i], m_mosi[i]);
          check("data_out", i, d_dout[i], m_dout[i]);
          check("mosi_moved_with_sclk_high", i, (d_mosi[i] !== p_mosi[i]) && d_sclk[i], 0);
        end
        if (d_sclk[i] && !p_sclk[i]) begin
          rises[i]++;
          mosi_rec[i] = {mosi_rec[i][14:0], d_mosi[i]};
        end
        if (!d_sclk[i] && p_sclk[i]) last_fall[i] = cyc;
        if (d_done[i]) dones[i]++;
        if (!d_busy[i] && p_bz[i]) busy_fall[i] = cyc;
        if (d_busy[i] && !p_bz[i]) begin
          accepts[i]++;
          last_low_run[i] = low_run[i];
        end
        if (d_busy[i]) begin busy_hi[i]++; low_run[i] = 0; end
        else low_run[i]++;
        p_sclk[i] = d_sclk[i]; p_mosi[i] = d_mosi[i]; p_bz[i] = d_busy[i];
      end
    end
  end

  task automatic pulse_start(input logic [W-1:0] d);
    @(negedge clk);
    start = 1'b1; data_in = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((d_busy[0] || d_busy[1] || m_active[0] || m_active[1]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, 0, (n >= 3000), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rises(input int target);
    int n;
    n = 0;
    while (rises[0] < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rise_wait_timeout", 0, (n >= 3000), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; start = 0; data_in = '0; miso_mode = 3; ena_mode = 3; per = 4; slave_byte = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_busy", i, d_busy[i], 0);
      check("rst_done", i, d_done[i], 0);
      check("rst_sclk", i, d_sclk[i], 0);
      check("rst_mosi", i, d_mosi[i], 0);
      check("rst_dout", i, d_dout[i], 0);
    end
    chk_en = 1;
    rst = 0;
    repeat (2) @(negedge clk);

    // Loopback 0x08, enable every 12 clocks.
    miso_mode = 0; ena_mode = 0; per = 12;
    clear_meas();
    pulse_start(8'h08);
    wait_idle("loopback");
    check("lb_rises", 0, rises[0], 8);
    check("lb_mosi_bits", 0, mosi_rec[0][7:0], 8'h08);
    check("lb_dones", 0, dones[0], 1);
    check("lb_dout", 0, d_dout[0], 8'h08);
    check("lb_gap_cycles", 0, busy_fall[0] - last_fall[0], 12);

    // Slave returns 0xA5 while 0xE8 goes out.
    miso_mode = 1; slave_byte = 8'hA5; per = 4;
    clear_meas();
    pulse_start(8'hE8);
    wait_idle("slave");
    check("sl_dout", 0, d_dout[0], 8'hA5);
    check("sl_dout", 1, d_dout[1], 8'hA5);
    check("sl_mosi_bits", 0, mosi_rec[0][7:0], 8'hE8);

    // start held across two transfers.
    miso_mode = 0;
    clear_meas();
    @(negedge clk);
    start = 1; data_in = 8'h0E;
    n = 0;
    while (!d_busy[0] && n < 100) begin @(negedge clk); n++; end
    data_in = 8'h03;
    while (accepts[0] < 2 && n < 3000) begin @(negedge clk); n++; end
    check("b2b_timeout", 0, (n >= 3000), 0);
    start = 0;
    wait_idle("b2b");
    check("b2b_rises", 0, rises[0], 16);
    check("b2b_dones", 0, dones[0], 2);
    check("b2b_mosi_bits", 0, mosi_rec[0], 16'h0E03);
    check("b2b_low_run", 0, last_low_run[0], 1);
    check("b2b_dout", 0, d_dout[0], 8'h03);

    // start pulsed at the 4th rising edge is ignored.
    clear_meas();
    pulse_start(8'h5C);
    wait_rises(4);
    pulse_start(8'hFF);
    wait_idle("ignore");
    repeat (30) @(negedge clk);
    check("ign_rises", 0, rises[0], 8);
    check("ign_dones", 0, dones[0], 1);
    check("ign_accepts", 0, accepts[0], 1);
    check("ign_mosi_bits", 0, mosi_rec[0][7:0], 8'h5C);
    check("ign_dout", 0, d_dout[0], 8'h5C);

    // Reset after the 5th rising edge.
    clear_meas();
    pulse_start(8'h3C);
    wait_rises(5);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_sclk", 0, d_sclk[0], 0);
    check("mid_rst_mosi", 0, d_mosi[0], 0);
    check("mid_rst_busy", 0, d_busy[0], 0);
    check("mid_rst_dout", 0, d_dout[0], 0);
    check("mid_rst_dones", 0, dones[0], 0);
    repeat (2) @(negedge clk);
    clear_meas();
    pulse_start(8'h96);
    wait_idle("after_rst");
    check("after_rst_dout", 0, d_dout[0], 8'h96);
    check("after_rst_dones", 0, dones[0], 1);

    // Enable tied high, miso held at one.
    miso_mode = 3; ena_mode = 1;
    clear_meas();
    pulse_start(8'hFF);
    wait_idle("tied");
    check("tied_busy_cycles", 1, busy_hi[1], 16);
    check("tied_busy_cycles", 0, busy_hi[0], 17);
    check("tied_fall_vs_busy", 1, busy_fall[1] - last_fall[1], 0);
    check("tied_dout", 1, d_dout[1], 8'hFF);
    check("tied_dout", 0, d_dout[0], 8'hFF);

    // Randomized transfers, enables, MISO and occasional resets.
    miso_mode = 2;
    for (int t = 0; t < 40; t++) begin
      ena_mode = $urandom_range(2);
      per = $urandom_range(1, 5);
      @(negedge clk);
      start = 1; data_in = W'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 0;
      if ($urandom_range(5) == 0) begin
        repeat ($urandom_range(2, 40)) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
      end
      wait_idle("random");
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
